// File: rtl/mem_responder.sv
// Word-addressed RAM slave for the tenyr fetch and data ports.
// Posted writes go through a one-entry buffer that forwards to reads.
module mem_responder #(
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] insn_addr,
    input  logic        insn_stb,
    output logic [31:0] insn_data,
    output logic        insn_ack,
    input  logic [31:0] norm_addr,
    input  logic        norm_rw,
    input  logic        norm_stb,
    inout  logic [31:0] norm_data,
    output logic        norm_ack,
    output logic        halt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t i_state, i_next;
    state_t n_state, n_next;

    logic [31:0] mem [DEPTH];

    logic                  wb_valid;
    logic [DEPTH_LOG2-1:0] wb_addr;
    logic [31:0]           wb_data;

    logic                  i_accept, n_accept;
    logic [32:0]           i_off, n_off;
    logic                  i_hit, n_hit;
    logic [DEPTH_LOG2-1:0] i_idx, n_idx;
    logic [31:0]           i_rd, n_rd;
    logic                  n_wr_cap;
    logic [31:0]           n_rdata;
    logic                  n_is_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            i_state <= IDLE;
            n_state <= IDLE;
        end else begin
            i_state <= i_next;
            n_state <= n_next;
        end
    end

    always_comb begin
        i_next   = i_state;
        i_accept = 1'b0;
        unique case (i_state)
            IDLE: begin
                if (insn_stb) begin
                    i_accept = 1'b1;
                    i_next   = ACK;
                end
            end
            ACK: i_next = IDLE;
        endcase
    end

    always_comb begin
        n_next   = n_state;
        n_accept = 1'b0;
        unique case (n_state)
            IDLE: begin
                if (norm_stb) begin
                    n_accept = 1'b1;
                    n_next   = ACK;
                end
            end
            ACK: n_next = IDLE;
        endcase
    end

    // 33-bit offset: a borrow in bit 32 means the address is below BASE
    always_comb begin
        i_off = {1'b0, insn_addr} - {1'b0, BASE};
        n_off = {1'b0, norm_addr} - {1'b0, BASE};
        i_hit = (i_off[32:DEPTH_LOG2] == '0);
        n_hit = (n_off[32:DEPTH_LOG2] == '0);
        i_idx = i_off[DEPTH_LOG2-1:0];
        n_idx = n_off[DEPTH_LOG2-1:0];
    end

    always_comb begin
        i_rd = 32'h0;
        n_rd = 32'h0;
        if (i_hit) begin
            if (wb_valid && wb_addr == i_idx) i_rd = wb_data;
            else i_rd = mem[i_idx];
        end
        if (n_hit) begin
            if (wb_valid && wb_addr == n_idx) n_rd = wb_data;
            else n_rd = mem[n_idx];
        end
        n_wr_cap = n_accept && norm_rw && n_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            insn_data <= 32'h0;
            n_rdata   <= 32'h0;
            n_is_rd   <= 1'b0;
            halt      <= 1'b0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= 32'h0;
        end else begin
            if (i_accept) begin
                insn_data <= i_rd;
                if (!i_hit) halt <= 1'b1;
            end
            if (n_accept) begin
                n_is_rd <= !norm_rw;
                n_rdata <= n_rd;
                if (!n_hit) halt <= 1'b1;
            end
            wb_valid <= n_wr_cap;
            if (n_wr_cap) begin
                wb_addr <= n_idx;
                wb_data <= norm_data;
            end
        end
    end

    // Drain is suppressed during reset so a pending write is dropped
    always_ff @(posedge clk) begin
        if (!reset && wb_valid) mem[wb_addr] <= wb_data;
    end

    assign insn_ack  = (i_state == ACK);
    assign norm_ack  = (n_state == ACK);
    assign norm_data = (n_state == ACK && n_is_rd) ? n_rdata : 32'bz;

endmodule
